// File: rtl/clk_div_meter.sv
// clk_div_meter: receive-side checker for divided clocks.
//
// Samples a divided clock (sig_in) on clk and measures its period and high time
// in clk cycles. Publishes both with a one-cycle meas_valid strobe at every
// rising edge that closes a full period. It raises locked after LOCK_CNT
// consecutive equal periods. It raises stall when no rising edge arrives before
// the period counter saturates.
//
// Ports:
//   clk         reference clock (same clock that feeds the divider under test)
//   rst         asynchronous active-low reset
//   sig_in      divided clock under test, asynchronous to clk
//   period_out  last measured period, clk cycles
//   high_out    last measured high time, clk cycles
//   meas_valid  one-cycle pulse when period_out/high_out update
//   locked      period stable for LOCK_CNT consecutive measurements
//   stall       no rising edge seen before the period counter saturated
//   duty_err    (only with CLK_DIV_METER_DUTY_CHECK_EN) |2*high - period| > 1
//
// Optional feature macro: CLK_DIV_METER_DUTY_CHECK_EN adds the duty_err output.
//
// state  | meaning
// WAIT   | no reference rising edge yet (after reset or stall); nothing to publish
// HIGH   | rising edge seen, counting the high phase
// LOW    | falling edge seen, high time held in hi_tmp, waiting for the next rise

module clk_div_meter #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
`ifdef CLK_DIV_METER_DUTY_CHECK_EN
  output logic             duty_err,
`endif
  output logic             stall
);

  localparam int MATCH_W = (LOCK_CNT > 2) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hi_tmp_q, hi_tmp_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               meas_valid_q, meas_valid_d;
  logic               locked_q, locked_d;
  logic               stall_q, stall_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               have_prev_q, have_prev_d;

  logic rise, fall, publish, stall_evt;

  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;

    if (rise)                 cnt_d = CNT_ONE;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    else                      cnt_d = cnt_q;

    state_d      = state_q;
    hi_tmp_d     = hi_tmp_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    stall_d      = stall_q;
    match_d      = match_q;
    have_prev_d  = have_prev_q;
    publish      = 1'b0;
    stall_evt    = 1'b0;

    // Stall fires on the edge where cnt enters all-ones, so a period that
    // would reach saturation is never published.
    case (state_q)
      ST_WAIT: begin
        if (rise) begin
          state_d = ST_HIGH;
          stall_d = 1'b0;
        end
      end
      ST_HIGH: begin
        // A rise without an intervening fall is a sub-cycle glitch; close the
        // period as if the low phase had been seen.
        if (rise)                  publish   = 1'b1;
        else if (cnt_d == CNT_MAX) stall_evt = 1'b1;
        else if (fall) begin
          hi_tmp_d = cnt_q;
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise)                  publish   = 1'b1;
        else if (cnt_d == CNT_MAX) stall_evt = 1'b1;
      end
      default: state_d = ST_WAIT;
    endcase

    if (publish) begin
      state_d      = ST_HIGH;
      period_d     = cnt_q;
      high_d       = hi_tmp_q;
      meas_valid_d = 1'b1;
      have_prev_d  = 1'b1;
      // have_prev is cleared by reset and stall, so the first publish after
      // either always counts as a mismatch.
      if (have_prev_q && (cnt_q == period_q)) begin
        if (match_q != MATCH_TOP) match_d = match_q + 1'b1;
      end else begin
        match_d = '0;
      end
      locked_d = (match_d == MATCH_TOP);
    end

    if (stall_evt) begin
      state_d     = ST_WAIT;
      stall_d     = 1'b1;
      locked_d    = 1'b0;
      match_d     = '0;
      have_prev_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_WAIT;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      hi_tmp_q     <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      stall_q      <= 1'b0;
      match_q      <= '0;
      have_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      cnt_q        <= cnt_d;
      hi_tmp_q     <= hi_tmp_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      stall_q      <= stall_d;
      match_q      <= match_d;
      have_prev_q  <= have_prev_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign stall      = stall_q;

`ifdef CLK_DIV_METER_DUTY_CHECK_EN
  // One extra bit so 2*high cannot overflow; the magnitude is taken unsigned.
  logic [CNT_W:0] high2, per_x, duty_diff;
  logic           duty_err_q, duty_err_d;

  always_comb begin
    high2     = {hi_tmp_q, 1'b0};
    per_x     = {1'b0, cnt_q};
    duty_diff = (high2 >= per_x) ? (high2 - per_x) : (per_x - high2);
    duty_err_d = duty_err_q;
    if (publish) duty_err_d = (duty_diff > (CNT_W+1)'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) duty_err_q <= 1'b0;
    else      duty_err_q <= duty_err_d;
  end

  assign duty_err = duty_err_q;
`endif

endmodule
